mouse_pos_tracker: RTL

// - Source of the mouse position pair consumed by the display pipeline's one-cycle position

---
 rtl/mouse_pos_tracker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mouse_pos_tracker.sv
// PS/2 mouse packet assembler: turns 3-byte packets into a clamped absolute screen position.
// Define MOUSE_WRAP_EN to make the position wrap at the screen edges instead of saturating.
module mouse_pos_tracker #(
    parameter int unsigned X_MAX   = 799,
    parameter int unsigned Y_MAX   = 599,
    parameter int unsigned X_INIT  = 400,
    parameter int unsigned Y_INIT  = 300,
    parameter int unsigned TIMEOUT = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        pos_valid,
    output logic        sync_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic signed [12:0] XMAX_S = 13'(X_MAX);
    localparam logic signed [12:0] YMAX_S = 13'(Y_MAX);
`ifdef MOUSE_WRAP_EN
    localparam logic signed [12:0] XSPAN = 13'(X_MAX + 1);
    localparam logic signed [12:0] YSPAN = 13'(Y_MAX + 1);
`endif

    typedef enum logic [1:0] {StWaitB0, StWaitB1, StWaitB2, StUpdate} state_e;

    state_e            state_q, state_d;
    // Header bits kept: {Y ovf, X ovf, Y sign, X sign, R, L}
    logic [5:0]        hdr_q, hdr_d;
    logic [7:0]        b1_q, b1_d, b2_q, b2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       xpos_q, xpos_d, ypos_q, ypos_d;
    logic              left_q, left_d, right_q, right_d;
    logic              pos_valid_q, pos_valid_d, sync_err_q, sync_err_d;

    logic signed [12:0] dx, dy, nx, ny;
    logic [11:0]        nx_fix, ny_fix;

    assign dx = hdr_q[4] ? 13'sd0 : {{5{hdr_q[2]}}, b1_q};
    assign dy = hdr_q[5] ? 13'sd0 : {{5{hdr_q[3]}}, b2_q};
    // PS/2 Y grows upward, screen Y grows downward
    assign nx = $signed({1'b0, xpos_q}) + dx;
    assign ny = $signed({1'b0, ypos_q}) - dy;

    always_comb begin
        nx_fix = 12'(nx);
        ny_fix = 12'(ny);
`ifdef MOUSE_WRAP_EN
        if (nx < 0)           nx_fix = 12'(nx + XSPAN);
        else if (nx > XMAX_S) nx_fix = 12'(nx - XSPAN);
        if (ny < 0)           ny_fix = 12'(ny + YSPAN);
        else if (ny > YMAX_S) ny_fix = 12'(ny - YSPAN);
`else
        if (nx < 0)           nx_fix = '0;
        else if (nx > XMAX_S) nx_fix = 12'(X_MAX);
        if (ny < 0)           ny_fix = '0;
        else if (ny > YMAX_S) ny_fix = 12'(Y_MAX);
`endif
    end

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        cnt_d       = cnt_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        left_d      = left_q;
        right_d     = right_q;
        pos_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        unique case (state_q)
            StWaitB0: begin
                cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data[3]) begin
                        hdr_d   = {rx_data[7:4], rx_data[1:0]};
                        state_d = StWaitB1;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            StWaitB1, StWaitB2: begin
                // Timeout takes priority over a coincident byte
                if (cnt_q == TO_VAL) begin
                    state_d    = StWaitB0;
                    sync_err_d = 1'b1;
                    cnt_d      = '0;
                end else if (rx_valid) begin
                    cnt_d = '0;
                    if (state_q == StWaitB1) begin
                        b1_d    = rx_data;
                        state_d = StWaitB2;
                    end else begin
                        b2_d    = rx_data;
                        state_d = StUpdate;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StUpdate: begin
                xpos_d      = nx_fix;
                ypos_d      = ny_fix;
                left_d      = hdr_q[0];
                right_d     = hdr_q[1];
                pos_valid_d = 1'b1;
                state_d     = StWaitB0;
            end
            default: state_d = StWaitB0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitB0;
            hdr_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            cnt_q       <= '0;
            xpos_q      <= 12'(X_INIT);
            ypos_q      <= 12'(Y_INIT);
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            pos_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            cnt_q       <= cnt_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            left_q      <= left_d;
            right_q     <= right_d;
            pos_valid_q <= pos_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign left      = left_q;
    assign right     = right_q;
    assign pos_valid = pos_valid_q;
    assign sync_err  = sync_err_q;

endmodule
